// File: rtl/adc_read_ctrl.sv
// -----------------------------------------------------------------------------
// adc_read_ctrl
//
// Sequences one SPI conversion read from the DAQ ADC:
//   1. wait for DRDY (active low, synchronized here),
//   2. assert CS and shift out the RDATA opcode MSB first,
//   3. idle SCLK low for the command-to-data delay (T6),
//   4. enable the external spi_rx and clock exactly DATA_WIDTH SCLK pulses,
//   5. once spi_rx reports a full word, latch it onto data_o with a one-cycle
//      data_valid_o pulse and release CS.
// In continuous mode the controller rearms to wait for the next DRDY instead
// of returning to IDLE.
//
// Ports
//   clock_i       in   1           system clock
//   reset_ni      in   1           asynchronous active-low reset
//   start_i       in   1           request one read (sampled in IDLE only)
//   continuous_i  in   1           at DONE: 1 = rearm, 0 = return to IDLE
//   DRDY_ni       in   1           ADC data-ready, active low, asynchronous
//   SCLK_o        out  1           SPI clock, idles low
//   CS_no         out  1           SPI chip select, active low
//   MOSI_o        out  1           SPI data to ADC
//   rx_en_o       out  1           enable to spi_rx; low clears its bit counter
//   rx_done_i     in   1           spi_rx has received DATA_WIDTH bits
//   rx_data_i     in   DATA_WIDTH  spi_rx parallel word
//   data_o        out  DATA_WIDTH  last captured word, held until next capture
//   data_valid_o  out  1           one-cycle pulse when data_o updates
//   busy_o        out  1           high in every state except IDLE
// -----------------------------------------------------------------------------
module adc_read_ctrl #(
    parameter int                  CLK_DIV    = 8,
    parameter int                  CMD_BITS   = 8,
    parameter logic [CMD_BITS-1:0] RDATA_CMD  = 8'h01,
    parameter int                  T6_CYCLES  = 50,
    parameter int                  DATA_WIDTH = 24
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  start_i,
    input  logic                  continuous_i,
    input  logic                  DRDY_ni,
    output logic                  SCLK_o,
    output logic                  CS_no,
    output logic                  MOSI_o,
    output logic                  rx_en_o,
    input  logic                  rx_done_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    output logic                  busy_o
);

    // -------------------------------------------------------------------------
    // Counter sizing
    // -------------------------------------------------------------------------
    localparam int MAX_BITS = (CMD_BITS > DATA_WIDTH) ? CMD_BITS : DATA_WIDTH;
    localparam int BIT_W    = $clog2(MAX_BITS) + 1;
    localparam int DIV_W    = $clog2(CLK_DIV) + 1;
    localparam int T6_W     = $clog2(T6_CYCLES) + 1;

    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] CMD_LAST  = BIT_W'(CMD_BITS - 1);
    localparam logic [BIT_W-1:0] DATA_CNT  = BIT_W'(DATA_WIDTH);
    localparam logic [T6_W-1:0]  T6_LAST   = T6_W'(T6_CYCLES - 1);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_DRDY = 3'd1;
    localparam logic [2:0] ST_CMD       = 3'd2;
    localparam logic [2:0] ST_T6_WAIT   = 3'd3;
    localparam logic [2:0] ST_READ      = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    // -------------------------------------------------------------------------
    // Registers and their next-state values
    // -------------------------------------------------------------------------
    logic [2:0]            state_reg,     state_next;
    logic                  sclk_reg,      sclk_next;
    logic                  cs_n_reg,      cs_n_next;
    logic                  mosi_reg,      mosi_next;
    logic                  rx_en_reg,     rx_en_next;
    logic [DATA_WIDTH-1:0] data_reg,      data_next;
    logic                  valid_reg,     valid_next;
    logic [DIV_W-1:0]      half_cnt_reg,  half_cnt_next;
    logic [BIT_W-1:0]      bit_cnt_reg,   bit_cnt_next;
    logic [T6_W-1:0]       t6_cnt_reg,    t6_cnt_next;
    logic [CMD_BITS-1:0]   cmd_shift_reg, cmd_shift_next;

    // DRDY synchronizer; resets to the inactive (high) level so a reset never
    // looks like a data-ready event.
    logic drdy_meta_reg;
    logic drdy_sync_reg;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            drdy_meta_reg <= 1'b1;
            drdy_sync_reg <= 1'b1;
        end else begin
            drdy_meta_reg <= DRDY_ni;
            drdy_sync_reg <= drdy_meta_reg;
        end
    end

    // End of an SCLK half-period: the SCLK level flips on this cycle's edge.
    logic half_tick;
    assign half_tick = (half_cnt_reg == HALF_LAST);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        sclk_next      = sclk_reg;
        cs_n_next      = cs_n_reg;
        mosi_next      = mosi_reg;
        rx_en_next     = rx_en_reg;
        data_next      = data_reg;
        valid_next     = 1'b0;
        half_cnt_next  = half_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        t6_cnt_next    = t6_cnt_reg;
        cmd_shift_next = cmd_shift_reg;

        case (state_reg)
            ST_IDLE: begin
                sclk_next = 1'b0;
                cs_n_next = 1'b1;
                if (start_i) begin
                    state_next = ST_WAIT_DRDY;
                end
            end

            ST_WAIT_DRDY: begin
                sclk_next = 1'b0;
                if (!drdy_sync_reg) begin
                    // MOSI carries the opcode MSB from the moment CS falls, so
                    // it is settled a full half-period before the first rise.
                    state_next     = ST_CMD;
                    cs_n_next      = 1'b0;
                    mosi_next      = RDATA_CMD[CMD_BITS-1];
                    cmd_shift_next = RDATA_CMD << 1;
                    half_cnt_next  = '0;
                    bit_cnt_next   = '0;
                end
            end

            ST_CMD: begin
                if (half_tick) begin
                    half_cnt_next = '0;
                    sclk_next     = ~sclk_reg;
                    // sclk_reg high here means this edge is a falling edge:
                    // the ADC has sampled the current bit, advance to the next.
                    if (sclk_reg) begin
                        if (bit_cnt_reg == CMD_LAST) begin
                            state_next   = ST_T6_WAIT;
                            mosi_next    = 1'b0;
                            t6_cnt_next  = '0;
                            rx_en_next   = 1'b1;
                            bit_cnt_next = '0;
                        end else begin
                            bit_cnt_next   = bit_cnt_reg + BIT_W'(1);
                            mosi_next      = cmd_shift_reg[CMD_BITS-1];
                            cmd_shift_next = cmd_shift_reg << 1;
                        end
                    end
                end else begin
                    half_cnt_next = half_cnt_reg + DIV_W'(1);
                end
            end

            ST_T6_WAIT: begin
                sclk_next = 1'b0;
                // READ starts with a fresh half-period, so the first data rise
                // lands CLK_DIV clocks after the T6 count expires.
                if (t6_cnt_reg == T6_LAST) begin
                    state_next    = ST_READ;
                    half_cnt_next = '0;
                    bit_cnt_next  = '0;
                end else begin
                    t6_cnt_next = t6_cnt_reg + T6_W'(1);
                end
            end

            ST_READ: begin
                if (bit_cnt_reg != DATA_CNT) begin
                    // Still clocking: rx_done_i is deliberately ignored until
                    // all DATA_WIDTH falling edges have been produced.
                    if (half_tick) begin
                        half_cnt_next = '0;
                        sclk_next     = ~sclk_reg;
                        if (sclk_reg) begin
                            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                        end
                    end else begin
                        half_cnt_next = half_cnt_reg + DIV_W'(1);
                    end
                end else begin
                    sclk_next = 1'b0;
                    if (rx_done_i) begin
                        // Capture and CS release happen on entry to DONE so
                        // the DONE cycle itself shows CS high and valid high.
                        state_next = ST_DONE;
                        data_next  = rx_data_i;
                        valid_next = 1'b1;
                        rx_en_next = 1'b0;
                        cs_n_next  = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                sclk_next     = 1'b0;
                half_cnt_next = '0;
                bit_cnt_next  = '0;
                state_next    = continuous_i ? ST_WAIT_DRDY : ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
                sclk_next  = 1'b0;
                cs_n_next  = 1'b1;
                mosi_next  = 1'b0;
                rx_en_next = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_reg     <= ST_IDLE;
            sclk_reg      <= 1'b0;
            cs_n_reg      <= 1'b1;
            mosi_reg      <= 1'b0;
            rx_en_reg     <= 1'b0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            half_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            t6_cnt_reg    <= '0;
            cmd_shift_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sclk_reg      <= sclk_next;
            cs_n_reg      <= cs_n_next;
            mosi_reg      <= mosi_next;
            rx_en_reg     <= rx_en_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            half_cnt_reg  <= half_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            t6_cnt_reg    <= t6_cnt_next;
            cmd_shift_reg <= cmd_shift_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all registered except busy, which decodes the state register)
    // -------------------------------------------------------------------------
    assign SCLK_o       = sclk_reg;
    assign CS_no        = cs_n_reg;
    assign MOSI_o       = mosi_reg;
    assign rx_en_o      = rx_en_reg;
    assign data_o       = data_reg;
    assign data_valid_o = valid_reg;
    assign busy_o       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_adc_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adc_read_ctrl
//
// Directed bench for adc_read_ctrl with CLK_DIV=2, T6_CYCLES=4. A negedge
// monitor plays both the ADC (shifts a word out MSB first on SCLK rises) and
// spi_rx (counts rises while rx_en is high, raises done at DATA_WIDTH bits),
// and records SCLK/CS edge times that the stimulus block checks afterwards.
// -----------------------------------------------------------------------------
module tb_adc_read_ctrl;

    localparam int CLK_DIV = 2;
    localparam int T6      = 4;
    localparam int DW      = 24;
    localparam int CMDB    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          continuous;
    logic          drdy_n;
    logic          sclk;
    logic          cs_n;
    logic          mosi;
    logic          rx_en;
    logic          rx_done = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic [DW-1:0] data;
    logic          data_valid;
    logic          busy;

    always #5 clk = ~clk;

    adc_read_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .CMD_BITS  (CMDB),
        .RDATA_CMD (8'h01),
        .T6_CYCLES (T6),
        .DATA_WIDTH(DW)
    ) dut (
        .clock_i     (clk),
        .reset_ni    (rst_n),
        .start_i     (start),
        .continuous_i(continuous),
        .DRDY_ni     (drdy_n),
        .SCLK_o      (sclk),
        .CS_no       (cs_n),
        .MOSI_o      (mosi),
        .rx_en_o     (rx_en),
        .rx_done_i   (rx_done),
        .rx_data_i   (rx_data),
        .data_o      (data),
        .data_valid_o(data_valid),
        .busy_o      (busy)
    );

    // ---------------------------------------------------------------- checker
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, required %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    int            cyc         = 0;
    int            n_rise      = 0;
    int            n_fall      = 0;
    int            cmd_rises   = 0;
    int            data_rises  = 0;
    int            n_valid     = 0;
    int            valid_cyc   = 0;
    int            n_cs_fall   = 0;
    int            cs_fall_cyc = 0;
    int            cs_rise_cyc = 0;
    int            cs_gap      = 0;
    int            bad_edges   = 0;
    int            rx_cnt      = 0;
    int            rise_cyc [1024];
    int            fall_cyc [1024];
    logic [7:0]    cmd_cap     = '0;
    logic [DW-1:0] valid_data  = '0;
    logic [DW-1:0] adc_word    = '0;
    logic [DW-1:0] adc_tx      = '0;
    logic [DW-1:0] rx_shift    = '0;
    logic          prev_sclk   = 1'b0;
    logic          prev_cs     = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (sclk && !prev_sclk) begin
            if (n_rise < 1024) rise_cyc[n_rise] = cyc;
            n_rise++;
            if (rx_en) begin
                rx_shift = {rx_shift[DW-2:0], adc_tx[DW-1]};
                adc_tx   = adc_tx << 1;
                rx_cnt++;
                data_rises++;
            end else if (!cs_n) begin
                cmd_cap = {cmd_cap[6:0], mosi};
                cmd_rises++;
            end
        end
        if (!sclk && prev_sclk) begin
            if (n_fall < 1024) fall_cyc[n_fall] = cyc;
            n_fall++;
        end
        if ((sclk !== prev_sclk) && cs_n) bad_edges++;
        if (!cs_n && prev_cs) begin
            n_cs_fall++;
            cs_fall_cyc = cyc;
            cs_gap      = cyc - cs_rise_cyc;
        end
        if (cs_n && !prev_cs) cs_rise_cyc = cyc;
        if (data_valid) begin
            n_valid++;
            valid_cyc  = cyc;
            valid_data = data;
        end
        if (!rx_en) begin
            rx_cnt = 0;
            adc_tx = adc_word;
        end
        rx_done   = rx_en && (rx_cnt == DW);
        rx_data   = rx_shift;
        prev_sclk = sclk;
        prev_cs   = cs_n;
    end

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int prev, input int limit, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (n_valid > prev) seen = 1'b1;
        end
    endtask

    task automatic wait_cs_low(input int limit, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (!cs_n) seen = 1'b1;
        end
    endtask

    // ---------------------------------------------------------------- stimulus
    logic seen;
    int   r0, f0, v0, c0, d0, cs0, drdy_cyc, bad_half;

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        drdy_n     = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_cs_n",  32'(cs_n),       32'd1);
        check("rst_sclk",  32'(sclk),       32'd0);
        check("rst_mosi",  32'(mosi),       32'd0);
        check("rst_rx_en", 32'(rx_en),      32'd0);
        check("rst_data",  32'(data),       32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single read of 24'hA5C30F, plus timing measurements on the same transfer
        r0 = n_rise; f0 = n_fall; v0 = n_valid; c0 = cmd_rises; d0 = data_rises;
        adc_word = 24'hA5C30F;
        pulse_start();
        check("t2_busy_wait", 32'(busy), 32'd1);
        tick();
        drdy_n   = 1'b0;
        drdy_cyc = cyc;
        wait_valid(v0, 400, seen);
        check("t2_valid_seen",  32'(seen),       32'd1);
        check("t2_valid_data",  32'(valid_data), 32'hA5C30F);
        check("t2_data_o",      32'(data),       32'hA5C30F);
        check("t2_valid_high",  32'(data_valid), 32'd1);
        check("t2_cs_in_done",  32'(cs_n),       32'd1);
        check("t2_mosi_opcode", 32'(cmd_cap),    32'h01);
        check("t2_latency",     32'(valid_cyc - drdy_cyc),
              32'(2 + 1 + 2*CLK_DIV*CMDB + T6 + 2*CLK_DIV*DW + 1));
        tick();
        check("t2_valid_low",   32'(data_valid), 32'd0);
        drdy_n = 1'b1;
        repeat (5) tick();
        check("t2_one_pulse",   32'(n_valid - v0),    32'd1);
        check("t2_busy_idle",   32'(busy),            32'd0);
        check("t2_cmd_rises",   32'(cmd_rises - c0),  32'(CMDB));
        check("t2_data_rises",  32'(data_rises - d0), 32'(DW));
        check("t2_fall_count",  32'(n_fall - f0),     32'(CMDB + DW));
        check("t2_data_held",   32'(data),            32'hA5C30F);
        check("t2_mosi_idle",   32'(mosi),            32'd0);

        bad_half = 0;
        for (int i = 0; i < CMDB + DW; i++) begin
            if (fall_cyc[f0+i] - rise_cyc[r0+i] != CLK_DIV) bad_half++;
        end
        for (int i = 0; i < CMDB + DW - 1; i++) begin
            if (i != CMDB - 1 && rise_cyc[r0+i+1] - fall_cyc[f0+i] != CLK_DIV) bad_half++;
        end
        check("t6_bad_half_periods", 32'(bad_half), 32'd0);
        check("t6_cs_to_first_rise", 32'(rise_cyc[r0] - cs_fall_cyc), 32'(CLK_DIV));
        check("t6_cmd_to_data_gap",  32'(rise_cyc[r0+CMDB] - fall_cyc[f0+CMDB-1]), 32'(T6 + CLK_DIV));

        // DRDY held high: nothing happens, controller stays busy
        cs0 = n_cs_fall; r0 = n_rise;
        pulse_start();
        repeat (1000) tick();
        check("t3_cs_high",   32'(cs_n),            32'd1);
        check("t3_no_cs_fall",32'(n_cs_fall - cs0), 32'd0);
        check("t3_no_sclk",   32'(n_rise - r0),     32'd0);
        check("t3_busy",      32'(busy),            32'd1);

        // Continuous: two reads, second one waits for a fresh DRDY low
        continuous = 1'b1;
        adc_word   = 24'h000001;
        v0         = n_valid;
        drdy_n     = 1'b0;
        wait_cs_low(20, seen);
        check("t4_cs1_seen", 32'(seen), 32'd1);
        drdy_n = 1'b1;
        wait_valid(v0, 400, seen);
        check("t4_valid1_seen", 32'(seen),       32'd1);
        check("t4_word1",       32'(valid_data), 32'h000001);
        adc_word = 24'hFFFFFF;
        cs0 = n_cs_fall;
        repeat (50) tick();
        check("t4_waits_drdy",  32'(n_cs_fall - cs0), 32'd0);
        check("t4_busy_rearm",  32'(busy),            32'd1);
        check("t4_cs_idle",     32'(cs_n),            32'd1);
        drdy_n   = 1'b0;
        drdy_cyc = cyc;
        wait_cs_low(20, seen);
        check("t4_cs2_seen",    32'(seen), 32'd1);
        check("t4_cs2_after_drdy", 32'(cs_fall_cyc - drdy_cyc), 32'd3);
        check("t4_cs_gap_ok",   32'(cs_gap >= 1), 32'd1);
        drdy_n     = 1'b1;
        continuous = 1'b0;
        wait_valid(v0 + 1, 400, seen);
        check("t4_valid2_seen", 32'(seen),          32'd1);
        check("t4_word2",       32'(valid_data),    32'hFFFFFF);
        check("t4_pulses",      32'(n_valid - v0),  32'd2);
        repeat (3) tick();
        check("t4_idle_after",  32'(busy),          32'd0);
        check("t4_no_stray_edges", 32'(bad_edges), 32'd0);

        // start_i hammered during a transfer: still exactly one read
        r0 = n_rise; v0 = n_valid; cs0 = n_cs_fall;
        adc_word = 24'h3C5A96;
        drdy_n   = 1'b0;
        seen     = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            start = ~start;
            tick();
            if (!cs_n) drdy_n = 1'b1;
            if (n_valid > v0) seen = 1'b1;
        end
        start = 1'b0;
        check("t5_valid_seen", 32'(seen), 32'd1);
        repeat (100) tick();
        check("t5_sclk_pulses", 32'(n_rise - r0),     32'(CMDB + DW));
        check("t5_one_valid",   32'(n_valid - v0),    32'd1);
        check("t5_one_cs",      32'(n_cs_fall - cs0), 32'd1);
        check("t5_word",        32'(data),            32'h3C5A96);
        check("t5_busy_idle",   32'(busy),            32'd0);

        // Reset asserted mid-READ while SCLK is high
        v0 = n_valid; d0 = data_rises;
        adc_word = 24'h123456;
        pulse_start();
        drdy_n = 1'b0;
        seen   = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            if (rx_en && sclk && (data_rises - d0) >= 5) seen = 1'b1;
        end
        check("t1_reached_read", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t1_cs_released", 32'(cs_n),  32'd1);
        check("t1_sclk_low",    32'(sclk),  32'd0);
        check("t1_rx_en_low",   32'(rx_en), 32'd0);
        check("t1_busy_low",    32'(busy),  32'd0);
        repeat (5) tick();
        check("t1_no_valid",    32'(n_valid - v0), 32'd0);
        check("t1_data_cleared",32'(data),         32'd0);
        drdy_n = 1'b1;
        rst_n  = 1'b1;
        repeat (3) tick();
        check("t1_idle_after",  32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
